// File: rtl/xor_columns_seq_if.sv
// Handshake bundle for the xor_columns_seq AddRoundKey engine.
// Input side: state, key and chain flag. Output side: result and busy.
interface xor_columns_seq_if #(
  parameter int W = 128
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] state_in;
  logic [W-1:0] key_in;
  logic         chain_en;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] state_out;
  logic         busy;

  modport master (
    output in_valid, state_in, key_in, chain_en, out_ready,
    input  in_ready, out_valid, state_out, busy
  );

  modport slave (
    input  in_valid, state_in, key_in, chain_en, out_ready,
    output in_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/xor_columns_seq.sv
// Sequential AddRoundKey: XORs the state with the key one column group per cycle.
// Optional chaining also XORs the last result that downstream accepted.
module xor_columns_seq #(
  parameter int BYTE_W         = 8,
  parameter int ROWS           = 4,
  parameter int NCOLS          = 4,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  xor_columns_seq_if.slave bus
);
  localparam int W     = ROWS * NCOLS * BYTE_W;
  localparam int CW    = ROWS * BYTE_W;
  localparam int G     = NCOLS / COLS_PER_CYCLE;
  localparam int IDX_W = (G > 1) ? $clog2(G) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if ((COLS_PER_CYCLE < 1) || (NCOLS % COLS_PER_CYCLE != 0)) begin : g_bad_param
      $error("xor_columns_seq: COLS_PER_CYCLE must divide NCOLS");
    end
  endgenerate

  logic [1:0]       state_reg;
  logic [IDX_W-1:0] col_idx_reg;
  logic [W-1:0]     st_reg;
  logic [W-1:0]     key_reg;
  logic             chain_reg;
  logic [W-1:0]     prev_reg;
  logic [W-1:0]     out_reg;
  logic             out_valid_reg;

  logic [W-1:0]     res;
  logic [W-1:0]     mask;
  logic             last_grp;

  assign res      = st_reg ^ key_reg ^ (prev_reg & {W{chain_reg}});
  assign last_grp = (col_idx_reg == IDX_W'(G - 1));

  // Column gi is written only while its group is the one being processed.
  generate
    for (genvar gi = 0; gi < NCOLS; gi++) begin : g_col_mask
      localparam int GRP = gi / COLS_PER_CYCLE;
      assign mask[gi*CW +: CW] = {CW{col_idx_reg == IDX_W'(GRP)}};
    end
  endgenerate

  assign bus.in_ready  = (state_reg == IDLE) && !rst;
  assign bus.out_valid = out_valid_reg;
  assign bus.state_out = out_reg;
  assign bus.busy      = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      col_idx_reg   <= '0;
      st_reg        <= '0;
      key_reg       <= '0;
      chain_reg     <= 1'b0;
      prev_reg      <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            st_reg      <= bus.state_in;
            key_reg     <= bus.key_in;
            chain_reg   <= bus.chain_en;
            out_reg     <= '0;
            col_idx_reg <= '0;
            state_reg   <= RUN;
          end
        end
        RUN: begin
          out_reg <= (out_reg & ~mask) | (res & mask);
          if (last_grp) begin
            col_idx_reg   <= '0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            col_idx_reg <= col_idx_reg + IDX_W'(1);
          end
        end
        DONE: begin
          // Only a delivered result may feed the next chained operation.
          if (bus.out_ready) begin
            prev_reg      <= out_reg;
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
